prog_delay_buf: RTL

PROG_DELAY_BUF -- requirements
Module: prog_delay_buf

---
 rtl/prog_delay_buf_mod_counter.sv | 40 ++++
 rtl/prog_delay_buf.sv | 100 ++++++++++
 2 files changed

// File: rtl/prog_delay_buf_mod_counter.sv
// Modulo-N pointer counter: counts 0..modulus-1 on inc and wraps explicitly,
// so non-power-of-two moduli behave the same as power-of-two ones.
module mod_counter #(
  parameter int PW = 3,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [DW-1:0] modulus,
  output logic [PW-1:0] cnt
);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          at_last;

  assign at_last = (DW'(cnt_q) == (modulus - DW'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = at_last ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prog_delay_buf.sv
// Programmable delay line: a ring of flop words whose active length is
// cur_depth; the entry at head is both the oldest output and the next write slot.
module prog_delay_buf #(
  parameter  int MAX_DEPTH = 8,
  parameter  int BITS      = 64,
  localparam int DW        = $clog2(MAX_DEPTH + 1),
  localparam int PW        = $clog2(MAX_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [BITS-1:0] d,
  input  logic            d_valid,
  output logic [BITS-1:0] q,
  output logic            q_valid,
  input  logic            cfg_load,
  input  logic [DW-1:0]   cfg_depth,
  input  logic            flush,
  output logic [DW-1:0]   cur_depth,
  output logic [DW-1:0]   occupancy,
  output logic            cfg_err
);

  logic [BITS-1:0]      data_q [MAX_DEPTH];
  logic [BITS-1:0]      data_d [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] vld_q;
  logic [MAX_DEPTH-1:0] vld_d;
  logic [DW-1:0]        cur_depth_q;
  logic [DW-1:0]        cur_depth_d;
  logic [DW-1:0]        occupancy_q;
  logic [DW-1:0]        occupancy_d;
  logic                 cfg_err_q;
  logic                 cfg_err_d;

  logic [PW-1:0]        head;
  logic                 cfg_ok;
  logic                 do_clear;
  logic                 do_write;

  // A cfg_load, accepted or not, masks flush and en in the same cycle.
  assign cfg_ok   = cfg_load && (cfg_depth != '0) && (cfg_depth <= DW'(MAX_DEPTH));
  assign do_clear = cfg_ok || (!cfg_load && flush);
  assign do_write = !cfg_load && !flush && en;

  mod_counter #(
    .PW (PW),
    .DW (DW)
  ) u_head (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (do_clear),
    .inc     (do_write),
    .modulus (cur_depth_q),
    .cnt     (head)
  );

  always_comb begin
    data_d      = data_q;
    vld_d       = vld_q;
    cur_depth_d = cur_depth_q;
    occupancy_d = occupancy_q;
    cfg_err_d   = cfg_load && !cfg_ok;
    if (do_clear) begin
      vld_d       = '0;
      occupancy_d = '0;
      if (cfg_ok) begin
        cur_depth_d = cfg_depth;
      end
    end else if (do_write) begin
      data_d[head] = d;
      vld_d[head]  = d_valid;
      occupancy_d  = occupancy_q + DW'(d_valid) - DW'(vld_q[head]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        data_q[i] <= '0;
      end
      vld_q       <= '0;
      cur_depth_q <= DW'(MAX_DEPTH);
      occupancy_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      data_q      <= data_d;
      vld_q       <= vld_d;
      cur_depth_q <= cur_depth_d;
      occupancy_q <= occupancy_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign q         = data_q[head];
  assign q_valid   = vld_q[head];
  assign cur_depth = cur_depth_q;
  assign occupancy = occupancy_q;
  assign cfg_err   = cfg_err_q;

endmodule
